// File: rtl/adc_spi_dual.sv
// SPI master for two ADCs that share CS_n/SCLK/MOSI. Each transfer sends one
// command word, captures one word from each MISO line, and hands both downstream.
module adc_spi_dual #(
    parameter int DIV    = 4,
    parameter int CS_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso_a,
    input  logic        miso_b,
    output logic [15:0] rxda,
    output logic [15:0] rxdb,
    output logic        fs,
    input  logic        fd
);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        SLOW  = 6'b000010,
        SHIGH = 6'b000100,
        TAIL  = 6'b001000,
        HAND  = 6'b010000,
        GAP   = 6'b100000
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_MAX  = 8'(CS_GAP);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state_q;
    logic [7:0]  divCnt_q;
    logic [3:0]  bitCnt_q;
    logic [7:0]  gapCnt_q;
    logic [15:0] txSr_q;
    logic [15:0] sra_q;
    logic [15:0] srb_q;
    logic        busy_q;
    logic        csN_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        fs_q;
    logic [15:0] rxda_q;
    logic [15:0] rxdb_q;

    logic phaseEnd;
    assign phaseEnd = (divCnt_q == DIV_LAST);

    // Every phase (low, high, tail) lasts DIV clocks; mosi always shows txSr_q[15].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            divCnt_q <= 8'd0;
            bitCnt_q <= 4'd15;
            gapCnt_q <= 8'd0;
            txSr_q   <= 16'd0;
            sra_q    <= 16'd0;
            srb_q    <= 16'd0;
            busy_q   <= 1'b0;
            csN_q    <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            fs_q     <= 1'b0;
            rxda_q   <= 16'd0;
            rxdb_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SLOW;
                        txSr_q   <= cmd;
                        bitCnt_q <= 4'd15;
                        divCnt_q <= 8'd0;
                        csN_q    <= 1'b0;
                        sclk_q   <= 1'b0;
                        mosi_q   <= cmd[15];
                        busy_q   <= 1'b1;
                    end
                end
                SLOW: begin
                    if (phaseEnd) begin
                        divCnt_q <= 8'd0;
                        sclk_q   <= 1'b1;
                        state_q  <= SHIGH;
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
                SHIGH: begin
                    if (phaseEnd) begin
                        divCnt_q <= 8'd0;
                        sclk_q   <= 1'b0;
                        sra_q    <= {sra_q[14:0], miso_a};
                        srb_q    <= {srb_q[14:0], miso_b};
                        if (bitCnt_q != 4'd0) begin
                            bitCnt_q <= bitCnt_q - 4'd1;
                            txSr_q   <= {txSr_q[14:0], 1'b0};
                            mosi_q   <= txSr_q[14];
                            state_q  <= SLOW;
                        end else begin
                            state_q  <= TAIL;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
                TAIL: begin
                    if (phaseEnd) begin
                        divCnt_q <= 8'd0;
                        csN_q    <= 1'b1;
                        mosi_q   <= 1'b0;
                        rxda_q   <= sra_q;
                        rxdb_q   <= srb_q;
                        fs_q     <= 1'b1;
                        state_q  <= HAND;
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
                HAND: begin
                    if (fd) begin
                        fs_q     <= 1'b0;
                        gapCnt_q <= 8'd0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    // gapCnt_q counts completed GAP cycles, so GAP_LAST here means CS_GAP have elapsed at this edge
                    if (gapCnt_q != GAP_MAX) begin
                        gapCnt_q <= gapCnt_q + 8'd1;
                    end
                    if (!fd && gapCnt_q >= GAP_LAST) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        bitCnt_q <= 4'd15;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign cs_n = csN_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign fs   = fs_q;
    assign rxda = rxda_q;
    assign rxdb = rxdb_q;

endmodule
